systolic_job_scheduler: RTL and testbench
=========================================

Name: systolic_job_scheduler

Overview:
Shares one systolic-array matrix multiplier between R requesters. Each requester submits a full N x N operand pair over a valid/ready handshake. A round-robin arbiter picks one job; the scheduler latches the operands, pulses the array's input-valid and waits for result-valid. It then captures C and returns it to the owning requester over a valid/ready response handshake. Sits directly above the array top and drives all of its input ports.

Parameters:
N, 4, matrix dimension; must equal the array's N.
R, 2, number of requesters; legal range 2..8.
WDOG_LIMIT, 32, BUSY-cycle timeout; used only with the watchdog macro; must exceed the array latency (12 cycles at N=4).

Ports:
i_clk  in  1  clock
i_arst  in  1  reset; synchronous, active-high
i_reqValid  in  R  job request per requester
o_reqReady  out  R  job accept; one-hot or zero
i_reqA  in  R*N*N*8  operand A per requester, row-major
i_reqB  in  R*N*N*8  operand B per requester
o_rspValid  out  R  result valid for the owning requester; one-hot or zero
i_rspReady  in  R  result accept per requester
o_rspC  out  N*N*32  result matrix, shared by all requesters
o_rspErr  out  1  result is a watchdog abort; qualified by o_rspValid
o_arrA  out  N*N*8  to array A input
o_arrB  out  N*N*8  to array B input
o_arrValidInput  out  1  one-cycle start pulse to the array
i_arrC  in  N*N*32  from array C output
i_arrValidResult  in  1  array result strobe
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (i_arst high at a posedge): state=IDLE, RR pointer=0, owner=0, all operand/result registers=0. All outputs 0 in the following cycle.
- Reset mid-job abandons the job; no response is issued. The array must be reset in the same cycle.
- FSM has four states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Arbiter grants the first requester with i_reqValid set, searching from the pointer upward with wrap.
  - o_reqReady[g]=1 combinationally, for the granted requester only.
  - On the handshake: latch i_reqA[g] and i_reqB[g] into o_arrA/o_arrB; owner=g; pointer=(g+1) mod R; go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: o_arrValidInput=1 for exactly one cycle. o_arrA/o_arrB stay stable from ISSUE until the next accept. Go to BUSY.
- BUSY:
  - Wait for i_arrValidResult. On the strobe, capture i_arrC into o_rspC, set o_rspErr=0 and go to RESP.
  - i_arrValidResult in any other state is ignored.
- RESP:
  - o_rspValid[owner]=1. o_rspC and o_rspErr are held stable until i_rspReady[owner]=1, then go to IDLE.
  - i_rspReady from non-owners is ignored.
- Throughput: one job in flight. The next accept is possible in the cycle after the response handshake.
- Request stability: a requester must keep its valid and operands stable until accepted. The scheduler never drops an asserted request; round-robin bounds its wait to R-1 intervening jobs.
- o_reqReady and o_rspValid are never both high in the same cycle.

Optional Feature:
SYSTOLIC_SCHED_WATCHDOG_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches WDOG_LIMIT with no strobe: go to RESP with o_rspC=0 and o_rspErr=1.
  - A strobe in the same cycle as the limit wins; that result is normal.
  - A late strobe arriving after the abort is ignored.
- Undefined: no counter is built; BUSY waits indefinitely; o_rspErr is tied to 0.

Decomposition:
- Package systolic_pkg:
  - Constants ELEM_W=8, ACC_W=32.
  - Typedefs elem_mat_t ([N][N][ELEM_W]) and acc_mat_t ([N][N][ACC_W]), parameterised through the localparam N default.
  - Enum sched_state_t {IDLE, ISSUE, BUSY, RESP}.
- One sub-module: rr_arbiter (parameter R; inputs req and enable; outputs one-hot grant and an advance strobe). The pointer register lives in the sub-module.

Test Plan:
1. Single job: requester 0 sends A=identity, B[i][j]=i*4+j -> one accept, one start pulse; o_rspValid[0] with o_rspC=B; o_rspErr=0.
2. Contention, R=2: both valid from reset -> grant order 0,1,0,1 over four jobs; each C correct; requester 1 never waits more than one job.
3. Response backpressure: i_rspReady[0] held low for 20 cycles -> o_rspValid[0] and o_rspC stable throughout; o_reqReady stays 0 even with requester 1 valid; accept occurs in the cycle after the handshake.
4. Reset mid-job: i_arst high during BUSY -> all outputs 0 next cycle; no response; a new job afterwards completes correctly.
5. Watchdog (macro defined, WDOG_LIMIT=32): array strobe suppressed -> RESP entered 32 cycles after BUSY entry, with o_rspErr=1 and o_rspC=0; a strobe injected later is ignored.
6. Spurious strobe: i_arrValidResult pulsed in IDLE and in RESP -> no state change; o_rspC unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic job scheduler.
//   ELEM_W / ACC_W : operand element width and result accumulator width
//   elem_mat_t     : N x N operand matrix, row-major
//   acc_mat_t      : N x N result matrix, row-major
//   sched_state_t  : scheduler FSM states
// Optional build macro used by the scheduler: SYSTOLIC_SCHED_WATCHDOG_EN
package systolic_pkg;

   localparam int N      = 4;
   localparam int ELEM_W = 8;
   localparam int ACC_W  = 32;

   typedef logic [N-1:0][N-1:0][ELEM_W-1:0] elem_mat_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0]  acc_mat_t;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} sched_state_t;

endpackage

// File: rtl/systolic_job_scheduler_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   i_clk, i_arst : clock, synchronous active-high reset (pointer -> 0)
//   i_req         : per-requester request
//   i_en          : arbitration allowed this cycle
//   o_grant       : one-hot grant (zero when disabled or no request)
//   o_adv         : a grant was issued; pointer moves past the winner
module rr_arbiter #(
   parameter int R = 2
) (
   input  logic         i_clk,
   input  logic         i_arst,
   input  logic [R-1:0] i_req,
   input  logic         i_en,
   output logic [R-1:0] o_grant,
   output logic         o_adv
);

   localparam int PW = $clog2(R);

   logic [PW-1:0] ptr_q, ptr_d;

   // Winner is the requester with the smallest wrapped distance from the pointer.
   always_comb begin
      int best_d;
      int d;
      best_d  = R;
      d       = 0;
      o_grant = '0;
      ptr_d   = ptr_q;
      for (int r = 0; r < R; r++) begin
         d = r - int'(ptr_q);
         if (d < 0) d = d + R;
         if (i_en && i_req[r] && (d < best_d)) begin
            best_d     = d;
            o_grant    = '0;
            o_grant[r] = 1'b1;
            ptr_d      = (r == R - 1) ? '0 : PW'(r + 1);
         end
      end
   end

   assign o_adv = |o_grant;

   always_ff @(posedge i_clk) begin
      if (i_arst) ptr_q <= '0;
      else if (o_adv) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Shares one systolic matrix multiplier between R requesters.
// One job in flight: accept (IDLE) -> start pulse (ISSUE) -> wait for the
// array result (BUSY) -> hold the result for the owner (RESP).
//   i_reqValid/o_reqReady/i_reqA/i_reqB : per-requester job handshake
//   o_rspValid/i_rspReady/o_rspC/o_rspErr : per-requester result handshake
//   o_arrA/o_arrB/o_arrValidInput        : drive the array inputs
//   i_arrC/i_arrValidResult              : array result
//   o_busy                               : high whenever not IDLE
// Build macro SYSTOLIC_SCHED_WATCHDOG_EN adds a BUSY timeout of WDOG_LIMIT
// cycles that returns a zero result flagged with o_rspErr.
module systolic_job_scheduler
   import systolic_pkg::*;
#(
   parameter int N          = 4,
   parameter int R          = 2,
   parameter int WDOG_LIMIT = 32
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic [R-1:0]         i_reqValid,
   output logic [R-1:0]         o_reqReady,
   input  logic [R*N*N*8-1:0]   i_reqA,
   input  logic [R*N*N*8-1:0]   i_reqB,
   output logic [R-1:0]         o_rspValid,
   input  logic [R-1:0]         i_rspReady,
   output logic [N*N*32-1:0]    o_rspC,
   output logic                 o_rspErr,
   output logic [N*N*8-1:0]     o_arrA,
   output logic [N*N*8-1:0]     o_arrB,
   output logic                 o_arrValidInput,
   input  logic [N*N*32-1:0]    i_arrC,
   input  logic                 i_arrValidResult,
   output logic                 o_busy
);

   localparam int MAT_W = N * N * ELEM_W;
   localparam int RES_W = N * N * ACC_W;
   localparam int OW    = $clog2(R);

   if (R < 2 || R > 8) begin : g_bad_r
      $error("systolic_job_scheduler: R must be within 2..8");
   end
   if (WDOG_LIMIT <= 3 * N) begin : g_bad_wdog
      $error("systolic_job_scheduler: WDOG_LIMIT must exceed the array latency");
   end

   sched_state_t     state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [MAT_W-1:0] arr_a_q, arr_a_d;
   logic [MAT_W-1:0] arr_b_q, arr_b_d;
   logic [RES_W-1:0] rsp_c_q, rsp_c_d;
   logic [R-1:0]     grant;
   logic             accept;

`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_LIMIT);
   logic          rsp_err_q, rsp_err_d;
   logic [WW-1:0] wdog_q, wdog_d;
`endif

   // Arbitration only runs in IDLE, so a grant is also the accept handshake.
   rr_arbiter #(.R(R)) u_arb (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_req   (i_reqValid),
      .i_en    (state_q == IDLE),
      .o_grant (grant),
      .o_adv   (accept)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      arr_a_d = arr_a_q;
      arr_b_d = arr_b_q;
      rsp_c_d = rsp_c_q;
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
      rsp_err_d = rsp_err_q;
      wdog_d    = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               for (int r = 0; r < R; r++) begin
                  if (grant[r]) begin
                     arr_a_d = i_reqA[r*MAT_W +: MAT_W];
                     arr_b_d = i_reqB[r*MAT_W +: MAT_W];
                     owner_d = OW'(r);
                  end
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = BUSY;
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
            wdog_d = '0;
`endif
         end
         BUSY: begin
            // A strobe on the final watchdog cycle still counts as a normal result.
            if (i_arrValidResult) begin
               rsp_c_d = i_arrC;
               state_d = RESP;
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
               rsp_err_d = 1'b0;
            end else if (wdog_q == WW'(WDOG_LIMIT - 1)) begin
               rsp_c_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
`endif
            end
         end
         RESP: begin
            if (i_rspReady[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q <= IDLE;
         owner_q <= '0;
         arr_a_q <= '0;
         arr_b_q <= '0;
         rsp_c_q <= '0;
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
         rsp_err_q <= 1'b0;
         wdog_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         arr_a_q <= arr_a_d;
         arr_b_q <= arr_b_d;
         rsp_c_q <= rsp_c_d;
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
         rsp_err_q <= rsp_err_d;
         wdog_q    <= wdog_d;
`endif
      end
   end

   always_comb begin
      o_rspValid = '0;
      if (state_q == RESP) o_rspValid[owner_q] = 1'b1;
   end

   assign o_reqReady      = grant;
   assign o_arrA          = arr_a_q;
   assign o_arrB          = arr_b_q;
   assign o_arrValidInput = (state_q == ISSUE);
   assign o_rspC          = rsp_c_q;
   assign o_busy          = (state_q != IDLE);
`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
   assign o_rspErr = rsp_err_q;
`else
   assign o_rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_job_scheduler.sv
`timescale 1ns/1ps
module tb_systolic_job_scheduler;

   localparam int N    = 4;
   localparam int R    = 2;
   localparam int WDOG = 32;
   localparam int MW   = N * N * 8;
   localparam int CW   = N * N * 32;

   logic              i_clk = 1'b0;
   logic              i_arst;
   logic [R-1:0]      i_reqValid, o_reqReady, o_rspValid, i_rspReady;
   logic [R*MW-1:0]   i_reqA, i_reqB;
   logic [CW-1:0]     o_rspC, i_arrC;
   logic              o_rspErr;
   logic [MW-1:0]     o_arrA, o_arrB;
   logic              o_arrValidInput, i_arrValidResult, o_busy;

   systolic_job_scheduler #(.N(N), .R(R), .WDOG_LIMIT(WDOG)) dut (
      .i_clk(i_clk), .i_arst(i_arst),
      .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
      .i_reqA(i_reqA), .i_reqB(i_reqB),
      .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
      .o_rspC(o_rspC), .o_rspErr(o_rspErr),
      .o_arrA(o_arrA), .o_arrB(o_arrB), .o_arrValidInput(o_arrValidInput),
      .i_arrC(i_arrC), .i_arrValidResult(i_arrValidResult),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [MW-1:0] a;
      logic [MW-1:0] b;
   } job_t;

   typedef struct packed {
      int            owner;
      logic [CW-1:0] c;
      logic          err;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   job_t pend [R][$];
   exp_t sbq[$];
   int   grant_log[$];
   int   ptr_m = 0;
   bit   in_flight = 0;
   int   done_cnt = 0, acc_cnt = 0, starts = 0;
   int   acc_cyc = 0, rsp_cyc = 0, rsp_first_cyc = 0, issue_cyc = 0;
   logic [CW-1:0] last_c;
   bit   expect_abort = 0;
   int   rsp_mode = 0;
   logic [R-1:0] rsp_force = '1;
   bit   arr_mute = 0, spur_req = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Plain matrix product of two row-major 8-bit unsigned matrices.
   function automatic logic [CW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [CW-1:0] c;
      int unsigned s;
      c = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
               s += int'(a[(i*N+k)*8 +: 8]) * int'(b[(k*N+j)*8 +: 8]);
            c[(i*N+j)*32 +: 32] = s;
         end
      return c;
   endfunction

   function automatic job_t rand_job();
      job_t j;
      for (int k = 0; k < N*N; k++) begin
         j.a[k*8 +: 8] = 8'($urandom_range(0, 255));
         j.b[k*8 +: 8] = 8'($urandom_range(0, 255));
      end
      return j;
   endfunction

   // Requester side: present queued jobs, drop/reload valid after each accept.
   logic [R-1:0] drv_acc;
   logic         drv_rst;
   initial begin
      i_reqValid = '0; i_reqA = '0; i_reqB = '0; i_rspReady = '1;
      forever begin
         @(negedge i_clk);
         drv_acc = i_arst ? '0 : (i_reqValid & o_reqReady);
         @(posedge i_clk);
         drv_rst = i_arst;
         #1;
         for (int r = 0; r < R; r++) begin
            if (drv_rst) i_reqValid[r] = 1'b0;
            else begin
               if (drv_acc[r]) begin
                  void'(pend[r].pop_front());
                  i_reqValid[r] = 1'b0;
               end
               if (!i_reqValid[r] && pend[r].size() > 0) begin
                  i_reqA[r*MW +: MW] = pend[r][0].a;
                  i_reqB[r*MW +: MW] = pend[r][0].b;
                  i_reqValid[r] = 1'b1;
               end
            end
         end
         case (rsp_mode)
            0:       i_rspReady = '1;
            1:       i_rspReady = R'($urandom_range(0, (1 << R) - 1));
            default: i_rspReady = rsp_force;
         endcase
      end
   end

   // Behavioural array: product of the operands seen at the start pulse,
   // returned after a variable latency.
   int            arr_cnt = 0;
   logic [CW-1:0] arr_res;
   logic          arr_rst;
   initial begin
      i_arrValidResult = 1'b0; i_arrC = '0; arr_res = '0;
      forever begin
         @(posedge i_clk);
         arr_rst = i_arst;
         #1;
         i_arrValidResult = 1'b0;
         if (arr_rst) arr_cnt = 0;
         else if (spur_req) begin
            for (int k = 0; k < N*N; k++) i_arrC[k*32 +: 32] = $urandom;
            i_arrValidResult = 1'b1;
            spur_req = 0;
         end else if (o_arrValidInput) begin
            arr_res = matmul(o_arrA, o_arrB);
            arr_cnt = 8 + $urandom_range(0, 6);
         end else if (arr_cnt > 0) begin
            arr_cnt--;
            if (arr_cnt == 0 && !arr_mute) begin
               i_arrC = arr_res;
               i_arrValidResult = 1'b1;
            end
         end
      end
   end

   // Reference model of the accept side: round-robin over the pending
   // requests whenever no job is outstanding; pushes the expected result.
   logic [R-1:0] m_rdy, m_hs;
   int           m_g, m_a;
   exp_t         m_e;
   initial forever begin
      @(negedge i_clk);
      if (i_arst) begin
         @(posedge i_clk);
         ptr_m = 0; in_flight = 0; sbq.delete();
         continue;
      end
      m_rdy = '0; m_g = -1;
      if (!in_flight)
         for (int d = 0; d < R; d++)
            if (m_g < 0 && i_reqValid[(ptr_m + d) % R]) m_g = (ptr_m + d) % R;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      check("req_ready", o_reqReady, m_rdy);
      check("busy", o_busy, in_flight);
      check("ready_and_rsp_overlap", (o_reqReady != 0) && (o_rspValid != 0), 1'b0);
      if (o_arrValidInput) begin
         starts++; issue_cyc = cyc;
         check("start_while_idle", in_flight, 1'b1);
      end
      m_hs = o_reqReady & i_reqValid;
      m_a = -1;
      for (int r = 0; r < R; r++) if (m_hs[r]) m_a = r;
      if (m_a >= 0) begin
         m_e.owner = m_a;
         m_e.c     = expect_abort ? '0 : matmul(i_reqA[m_a*MW +: MW], i_reqB[m_a*MW +: MW]);
         m_e.err   = expect_abort;
         grant_log.push_back(m_a);
         acc_cyc = cyc;
      end
      @(posedge i_clk);
      if (m_a >= 0) begin
         sbq.push_back(m_e); in_flight = 1; ptr_m = (m_a + 1) % R; acc_cnt++;
      end
   end

   // Response monitor: compares each presented result against the scoreboard.
   bit            r_held = 0, r_hs;
   logic [R-1:0]  r_pv, r_ev;
   logic [CW-1:0] r_pc;
   logic          r_pe;
   exp_t          r_e;
   initial forever begin
      @(negedge i_clk);
      r_hs = 0;
      if (i_arst) begin
         @(posedge i_clk);
         r_held = 0;
         continue;
      end
      if (r_held) begin
         check("hold_valid", o_rspValid, r_pv);
         check("hold_c", o_rspC, r_pc);
         check("hold_err", o_rspErr, r_pe);
      end
      if (o_rspValid != 0) begin
         if (!r_held) rsp_first_cyc = cyc;
         if (sbq.size() == 0) check("rsp_unexpected", o_rspValid, '0);
         else begin
            r_e = sbq[0];
            r_ev = '0; r_ev[r_e.owner] = 1'b1;
            check("rsp_owner", o_rspValid, r_ev);
            check("rsp_c", o_rspC, r_e.c);
            check("rsp_err", o_rspErr, r_e.err);
            r_hs = (o_rspValid & i_rspReady) != 0;
         end
         r_held = !r_hs;
         r_pv = o_rspValid; r_pc = o_rspC; r_pe = o_rspErr;
      end else r_held = 0;
      if (r_hs) begin
         rsp_cyc = cyc; last_c = o_rspC;
      end
      @(posedge i_clk);
      if (r_hs) begin
         void'(sbq.pop_front()); in_flight = 0; done_cnt++;
      end
   end

   task automatic wait_done(input int target, input string nm);
      int n = 0;
      while (done_cnt < target && n < 3000) begin @(negedge i_clk); n++; end
      check(nm, done_cnt >= target, 1'b1);
   endtask

   task automatic wait_acc(input int target, input string nm);
      int n = 0;
      while (acc_cnt < target && n < 500) begin @(negedge i_clk); n++; end
      check(nm, acc_cnt >= target, 1'b1);
   endtask

   task automatic wait_rsp0(input string nm);
      int n = 0;
      while (o_rspValid[0] !== 1'b1 && n < 500) begin @(negedge i_clk); n++; end
      check(nm, o_rspValid[0], 1'b1);
   endtask

   task automatic check_outputs_zero(input string nm);
      check({nm, "_reqReady"}, o_reqReady, '0);
      check({nm, "_rspValid"}, o_rspValid, '0);
      check({nm, "_rspC"}, o_rspC, '0);
      check({nm, "_rspErr"}, o_rspErr, 1'b0);
      check({nm, "_arrA"}, o_arrA, '0);
      check({nm, "_arrB"}, o_arrB, '0);
      check({nm, "_arrValid"}, o_arrValidInput, 1'b0);
      check({nm, "_busy"}, o_busy, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1);
   end

   job_t          j;
   logic [CW-1:0] c_b, c_save;
   int            base, s0;

   initial begin
      i_arst = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 i_arst = 1'b0;
      @(negedge i_clk);
      check_outputs_zero("reset");

      // Single job: identity times a ramp returns the ramp.
      j = '0; c_b = '0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            j.a[(i*N+k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
            j.b[(i*N+k)*8 +: 8] = 8'(i*4 + k);
            c_b[(i*N+k)*32 +: 32] = i*4 + k;
         end
      s0 = starts;
      pend[0].push_back(j);
      wait_done(1, "t1_done");
      check("t1_c_is_b", last_c, c_b);
      check("t1_one_start", starts - s0, 1);
      check("t1_one_accept", acc_cnt, 1);

      // Contention from reset: both requesters hold two jobs each.
      @(posedge i_clk); #1 i_arst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pend[0].push_back(rand_job());
         pend[1].push_back(rand_job());
      end
      @(posedge i_clk); #1 i_arst = 1'b0;
      grant_log.delete();
      base = done_cnt;
      wait_done(base + 4, "t2_done");
      check("t2_njobs", grant_log.size(), 4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check("t2_order", grant_log[k], k % 2);

      // Response backpressure with the other requester waiting.
      @(negedge i_clk);
      rsp_mode = 2; rsp_force = 2'b10;
      base = done_cnt;
      pend[0].push_back(rand_job());
      wait_rsp0("t3_rsp_seen");
      pend[1].push_back(rand_job());
      base = acc_cnt;
      repeat (20) @(negedge i_clk);
      check("t3_no_accept_while_held", acc_cnt, base);
      rsp_force = 2'b11;
      wait_acc(base + 1, "t3_next_accept");
      check("t3_accept_after_hs", acc_cyc - rsp_cyc, 1);
      wait_done(done_cnt + 1, "t3_done");
      rsp_mode = 0;

      // Reset while the array is working.
      @(negedge i_clk);
      base = done_cnt; s0 = starts;
      pend[0].push_back(rand_job());
      begin
         int n = 0;
         while (starts == s0 && n < 100) begin @(negedge i_clk); n++; end
      end
      check("t4_started", starts - s0, 1);
      repeat (3) @(negedge i_clk);
      check("t4_busy_before_reset", o_busy, 1'b1);
      @(posedge i_clk); #1 i_arst = 1'b1;
      @(posedge i_clk); #1 i_arst = 1'b0;
      @(negedge i_clk);
      check_outputs_zero("t4_after_reset");
      repeat (25) @(negedge i_clk);
      check("t4_no_response", done_cnt, base);
      pend[1].push_back(rand_job());
      wait_done(base + 1, "t4_new_job");

      // Spurious array strobes in IDLE and in RESP.
      @(negedge i_clk);
      c_save = o_rspC;
      spur_req = 1;
      repeat (4) @(negedge i_clk);
      check("t6_idle_busy", o_busy, 1'b0);
      check("t6_idle_c", o_rspC, c_save);
      rsp_mode = 2; rsp_force = 2'b10;
      base = done_cnt;
      pend[0].push_back(rand_job());
      wait_rsp0("t6_rsp_seen");
      c_save = o_rspC;
      spur_req = 1;
      repeat (4) @(negedge i_clk);
      check("t6_resp_c", o_rspC, c_save);
      check("t6_resp_valid", o_rspValid, 2'b01);
      rsp_force = 2'b11;
      wait_done(base + 1, "t6_done");
      rsp_mode = 0;

`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
      // Watchdog abort with the array silent, then a late strobe.
      @(negedge i_clk);
      arr_mute = 1; expect_abort = 1;
      rsp_mode = 2; rsp_force = 2'b10;
      base = done_cnt;
      pend[0].push_back(rand_job());
      wait_rsp0("t5_abort_seen");
      check("t5_abort_delay", rsp_first_cyc - issue_cyc, WDOG + 1);
      check("t5_abort_err", o_rspErr, 1'b1);
      check("t5_abort_c", o_rspC, '0);
      arr_mute = 0; spur_req = 1;
      repeat (4) @(negedge i_clk);
      check("t5_late_strobe_c", o_rspC, '0);
      rsp_force = 2'b11;
      wait_done(base + 1, "t5_done");
      expect_abort = 0; rsp_mode = 0;
`endif

      // Randomized traffic with random response backpressure.
      rsp_mode = 1;
      base = done_cnt;
      for (int k = 0; k < 16; k++) begin
         pend[$urandom_range(0, R-1)].push_back(rand_job());
         repeat ($urandom_range(0, 6)) @(negedge i_clk);
      end
      wait_done(base + 16, "rand_done");
      rsp_mode = 0;

      repeat (5) @(negedge i_clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
